// File: rtl/tg.sv
// tg: AXI-Stream traffic generator with selectable data patterns and optional rate limiting.
// Optional feature: define TG_LFSR_EN to build the LFSR data pattern (mode[3:2] = 2'b10).
// Without it, no LFSR logic is built and that pattern falls back to the flit counter.
module tg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         mode,
  input  logic [15:0]        num_packets,
  input  logic [15:0]        num_flits,
  input  logic [7:0]         last_flit_bytes,
  input  logic [15:0]        M,
  input  logic [15:0]        N,
  output logic [WIDTH-1:0]   TDATA,
  output logic [WIDTH/8-1:0] TKEEP,
  output logic               TVALID,
  input  logic               TREADY,
  output logic               TLAST
);

  localparam int unsigned KW = WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e      state_q, state_d;
  logic        armed_q;
  logic [31:0] flit_cnt_q, flit_cnt_d;
  logic [15:0] pkt_idx_q, pkt_idx_d;
  logic [15:0] flit_idx_q, flit_idx_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        load;

  // Per-packet copies of the configuration inputs
  logic        cont_q;
  logic [1:0]  pat_q;
  logic        rate_q;
  logic [15:0] npk_q, nfl_q, m_q, n_q;
  logic [7:0]  lfb_q;

  logic [15:0] nf_eff;
  logic        is_last, rate_on, burst_full, run_end;
  logic [31:0] lfb32;

  // mode[5] is reserved and intentionally ignored
  logic unused_mode5;
  assign unused_mode5 = mode[5];

  assign nf_eff     = (nfl_q == 16'd0) ? 16'd1 : nfl_q;
  assign is_last    = (flit_idx_q == nf_eff - 16'd1);
  assign rate_on    = rate_q && (m_q != 16'd0);
  assign burst_full = rate_on && (({1'b0, burst_cnt_q} + 17'd1) >= {1'b0, m_q});
  assign run_end    = is_last && !cont_q && ((pkt_idx_q + 16'd1) == npk_q);
  assign lfb32      = {24'd0, lfb_q};

`ifdef TG_LFSR_EN
  logic [31:0] lfsr_q, lfsr_d;

  // Galois LFSR x^32+x^22+x^2+x+1, advanced once per accepted flit
  always_comb begin
    lfsr_d = lfsr_q;
    if ((state_q == StSend) && TREADY) begin
      lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? 32'h0040_0007 : 32'h0);
    end
  end

  // LFSR register, seeded with all ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 32'hFFFF_FFFF;
    else      lfsr_q <= lfsr_d;
  end
`endif

  // Next-state logic: packet/flit sequencing, burst accounting and gap countdown
  always_comb begin
    state_d     = state_q;
    flit_cnt_d  = flit_cnt_q;
    pkt_idx_d   = pkt_idx_q;
    flit_idx_d  = flit_idx_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    load        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (armed_q && mode[0]) begin
          if (mode[1] || (num_packets != 16'd0)) begin
            state_d     = StSend;
            load        = 1'b1;
            pkt_idx_d   = '0;
            flit_idx_d  = '0;
            burst_cnt_d = '0;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSend: begin
        if (TREADY) begin
          flit_cnt_d  = flit_cnt_q + 32'd1;
          burst_cnt_d = burst_full ? 16'd0 : (rate_on ? burst_cnt_q + 16'd1 : 16'd0);
          if (is_last) begin
            flit_idx_d = '0;
            pkt_idx_d  = pkt_idx_q + 16'd1;
          end else begin
            flit_idx_d = flit_idx_q + 16'd1;
          end
          if (run_end) begin
            state_d = StDone;
          end else if (is_last && !mode[0]) begin
            // Enable dropped during the packet: finish it, then stop
            state_d = StIdle;
          end else begin
            load = is_last;
            if (burst_full && (n_q != 16'd0)) begin
              state_d   = StGap;
              gap_cnt_d = n_q - 16'd1;
            end
          end
        end
      end
      StGap: begin
        if (!mode[0] && (flit_idx_q == 16'd0)) begin
          state_d = StIdle;
        end else if (gap_cnt_q == 16'd0) begin
          state_d = StSend;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      StDone: begin
        if (!mode[0]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      armed_q     <= 1'b0;
      flit_cnt_q  <= '0;
      pkt_idx_q   <= '0;
      flit_idx_q  <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= 1'b1;
      flit_cnt_q  <= flit_cnt_d;
      pkt_idx_q   <= pkt_idx_d;
      flit_idx_q  <= flit_idx_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Capture configuration ahead of each packet's first flit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cont_q <= 1'b0;
      pat_q  <= '0;
      rate_q <= 1'b0;
      npk_q  <= '0;
      nfl_q  <= '0;
      lfb_q  <= '0;
      m_q    <= '0;
      n_q    <= '0;
    end else if (load) begin
      cont_q <= mode[1];
      pat_q  <= mode[3:2];
      rate_q <= mode[4];
      npk_q  <= num_packets;
      nfl_q  <= num_flits;
      lfb_q  <= last_flit_bytes;
      m_q    <= M;
      n_q    <= N;
    end
  end

  // Stream outputs, all zero while no flit is offered
  always_comb begin
    TVALID = (state_q == StSend);
    TLAST  = TVALID && is_last;
    TKEEP  = '0;
    TDATA  = '0;
    if (TVALID) begin
      TKEEP = '1;
      if (is_last && (lfb32 != 32'd0) && (lfb32 <= KW)) begin
        for (int unsigned i = 0; i < KW; i++) TKEEP[i] = (i < lfb32);
      end
      case (pat_q)
        2'b00: TDATA[31:0] = flit_cnt_q;
        2'b01: TDATA[31:0] = {pkt_idx_q, flit_idx_q};
        2'b10: begin
`ifdef TG_LFSR_EN
          for (int unsigned b = 0; b < WIDTH; b++) TDATA[b] = lfsr_q[b[4:0]];
`else
          TDATA[31:0] = flit_cnt_q;
`endif
        end
        default: TDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_tg.sv
// tb_tg: scenario table plus hand-written corner sequences for tg, scoreboard-checked.
module tb_tg;
  localparam int unsigned W  = 64;
  localparam int unsigned KW = W / 8;

  logic          clk, rst, tready;
  logic [5:0]    mode;
  logic [15:0]   num_packets, num_flits, m_val, n_val;
  logic [7:0]    lfb;
  logic [W-1:0]  tdata;
  logic [KW-1:0] tkeep;
  logic          tvalid, tlast;

  tg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .num_packets(num_packets), .num_flits(num_flits),
    .last_flit_bytes(lfb), .M(m_val), .N(n_val), .TDATA(tdata), .TKEEP(tkeep),
    .TVALID(tvalid), .TREADY(tready), .TLAST(tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } flit_t;

  typedef struct {
    logic [5:0] mode;
    int np, nf, lfb, m, n;
    bit tog;
    int exp_flits, exp_gaps, exp_bursts;
  } vec_t;

  flit_t       exp_q[$];
  vec_t        vecs[8];
  int          total, bad;
  int          n_acc, gap_cycles, bursts;
  bit          toggle_ready;
  logic        prev_valid, prev_stall;
  flit_t       prev_flit;
  logic [31:0] model_cnt, model_lfsr;

  // Ready driver: always ready, or alternating each cycle
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = toggle_ready ? ~tready : 1'b1;
    end
  end

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] sh;
    sh = {s[30:0], 1'b0};
    return s[31] ? (sh ^ 32'h0040_0007) : sh;
  endfunction

  task automatic push_run(input logic [1:0] pat, input int np, input int nf, input int nb);
    int nfe;
    flit_t e;
    logic [15:0] p16, f16;
    nfe = (nf == 0) ? 1 : nf;
    for (int p = 0; p < np; p++) begin
      for (int f = 0; f < nfe; f++) begin
        e.last = (f == nfe - 1);
        e.keep = '1;
        if (e.last && nb > 0 && nb <= int'(KW)) e.keep = e.keep >> (int'(KW) - nb);
        p16 = p[15:0];
        f16 = f[15:0];
        e.data = '0;
        case (pat)
          2'b00: e.data[31:0] = model_cnt;
          2'b01: e.data[31:0] = {p16, f16};
          2'b10: begin
`ifdef TG_LFSR_EN
            e.data = {2{model_lfsr}};
`else
            e.data[31:0] = model_cnt;
`endif
          end
          default: e.data = '0;
        endcase
        exp_q.push_back(e);
        model_cnt  = model_cnt + 32'd1;
        model_lfsr = lfsr_next(model_lfsr);
      end
    end
  endtask

  // One clock cycle; samples the bus on the falling edge and scores it
  task automatic cycle();
    flit_t e, cur;
    @(negedge clk);
    cur = {tdata, tkeep, tlast};
    if (!rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      total++;
      if (!tvalid || cur != prev_flit) begin
        bad++;
        $display("FAIL hold: valid=%b flit=%h, required valid=1 flit=%h", tvalid, cur, prev_flit);
      end
    end
    if (tvalid && !prev_valid) bursts++;
    if (!tvalid && n_acc > 0 && exp_q.size() != 0) gap_cycles++;
    if (tvalid && tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL extra flit: data=%h keep=%h last=%b, required none", tdata, tkeep, tlast);
      end else begin
        e = exp_q.pop_front();
        if (cur != e) begin
          bad++;
          $display("FAIL flit%0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                   n_acc, tdata, tkeep, tlast, e.data, e.keep, e.last);
        end
      end
      n_acc++;
    end
    prev_valid = tvalid;
    prev_stall = tvalid && !tready;
    prev_flit  = cur;
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_cnt  = 32'd0;
    model_lfsr = 32'hFFFF_FFFF;
    n_acc      = 0;
    gap_cycles = 0;
    bursts     = 0;
    prev_valid = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== '0 || tkeep !== '0) begin
      bad++;
      $display("FAIL %s: valid=%b last=%b data=%h keep=%h, required all zero",
               name, tvalid, tlast, tdata, tkeep);
    end
  endtask

  task automatic do_reset();
    mode = 6'd0;
    rst  = 1'b0;
    repeat (2) cycle();
    check_reset_outputs("reset_state");
    rst = 1'b1;
    clear_model();
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s timeout: %0d flits outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (n_acc < target && k < budget) begin
      cycle();
      k++;
    end
    total++;
    if (n_acc < target) begin
      bad++;
      $display("FAIL %s timeout: accepted=%0d, required %0d", name, n_acc, target);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    toggle_ready = 1'b0;
    mode = 6'b000001;
    num_packets = 16'd1;
    num_flits = 16'd1;
    lfb = 8'd0;
    m_val = 16'd0;
    n_val = 16'd0;
    rst = 1'b0;
    clear_model();

    // Reset values and first-valid latency with enable held through release
    cycle();
    check_reset_outputs("reset_initial");
    rst = 1'b1;
    push_run(2'b00, 1, 1, 0);
    cycle();
    check_int("latency_edge1_valid", int'(tvalid), 0);
    cycle();
    check_int("latency_edge2_valid", int'(tvalid), 1);
    wait_empty("latency_run", 50);
    mode = 6'd0;
    repeat (2) cycle();

    //          mode        np nf lfb m  n  tog flits gaps bursts
    vecs[0] = '{6'b000001, 2, 3, 5, 0, 0, 0, 6, 0, 1};
    vecs[1] = '{6'b000001, 2, 3, 5, 0, 0, 1, 6, 0, 1};
    vecs[2] = '{6'b010101, 1, 5, 0, 2, 3, 0, 5, 6, 3};
    vecs[3] = '{6'b001001, 1, 4, 8, 0, 0, 0, 4, 0, 1};
    vecs[4] = '{6'b001101, 1, 2, 9, 0, 0, 0, 2, 0, 1};
    vecs[5] = '{6'b000001, 3, 0, 3, 0, 0, 0, 3, 0, 1};
    vecs[6] = '{6'b010101, 2, 2, 1, 0, 4, 0, 4, 0, 1};
    vecs[7] = '{6'b110001, 1, 3, 2, 1, 0, 0, 3, 0, 1};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      num_packets  = 16'(vecs[v].np);
      num_flits    = 16'(vecs[v].nf);
      lfb          = 8'(vecs[v].lfb);
      m_val        = 16'(vecs[v].m);
      n_val        = 16'(vecs[v].n);
      toggle_ready = vecs[v].tog;
      push_run(vecs[v].mode[3:2], vecs[v].np, vecs[v].nf, vecs[v].lfb);
      mode = vecs[v].mode;
      wait_empty($sformatf("vec%0d", v), 200);
      repeat (4) cycle();
      check_int($sformatf("vec%0d_flits", v), n_acc, vecs[v].exp_flits);
      check_int($sformatf("vec%0d_gaps", v), gap_cycles, vecs[v].exp_gaps);
      check_int($sformatf("vec%0d_bursts", v), bursts, vecs[v].exp_bursts);
      check_int($sformatf("vec%0d_done_valid", v), int'(tvalid), 0);
      toggle_ready = 1'b0;
      mode = 6'd0;
      repeat (2) cycle();
    end

    // Enable dropped during the second flit: packet completes, no further packets
    do_reset();
    num_packets = 16'd5;
    num_flits = 16'd4;
    lfb = 8'd4;
    m_val = 16'd0;
    n_val = 16'd0;
    push_run(2'b00, 1, 4, 4);
    mode = 6'b000001;
    wait_acc("stop_flit2", 2, 50);
    mode = 6'd0;
    wait_empty("stop_run", 50);
    repeat (5) cycle();
    check_int("stop_flits", n_acc, 4);
    check_int("stop_valid", int'(tvalid), 0);

    // Reset mid-packet aborts it; the next run restarts the counter at zero
    do_reset();
    num_packets = 16'd1;
    num_flits = 16'd6;
    lfb = 8'd0;
    push_run(2'b00, 1, 6, 0);
    mode = 6'b000001;
    wait_acc("abort_mid", 2, 50);
    #2;
    rst = 1'b0;
    #1;
    check_int("abort_valid_now", int'(tvalid), 0);
    repeat (2) cycle();
    num_flits = 16'd2;
    clear_model();
    push_run(2'b00, 1, 2, 0);
    rst = 1'b1;
    wait_empty("abort_restart", 50);
    repeat (4) cycle();
    check_int("abort_restart_flits", n_acc, 2);
    mode = 6'd0;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
